data_width_downsizer: RTL and testbench



---
 rtl/dwc_pkg.sv | 26 ++
 rtl/dwc_slice_mux.sv | 25 ++
 rtl/data_width_downsizer.sv | 112 +++++++++++
 tb/tb_data_width_downsizer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dwc_pkg.sv
// Shared types and helpers for the data width downsizer.
// Slice ordering is selected by DWC_LSB_FIRST_EN (default MSB-first).
package dwc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

`ifdef DWC_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  // Low bit position of emitted slice idx within the input word.
  function automatic int slice_lo(input int idx, input int in_w, input int out_w,
                                  input bit lsb_first);
    return lsb_first ? (idx * out_w) : (in_w - (idx + 1) * out_w);
  endfunction

  function automatic bit params_ok(input int in_w, input int out_w);
    return (out_w > 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
  endfunction

endpackage

// File: rtl/dwc_slice_mux.sv
// Combinational selector returning the idx-th emitted slice of a word.
// Ordering follows dwc_pkg::LSB_FIRST (DWC_LSB_FIRST_EN).
module dwc_slice_mux
  import dwc_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  localparam int RATIO = IN_W / OUT_W,
  localparam int CNT_W = $clog2(RATIO)
) (
  input  logic [IN_W-1:0]  word,
  input  logic [CNT_W-1:0] idx,
  output logic [OUT_W-1:0] slice
);

  always_comb begin
    slice = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (idx == CNT_W'(k)) begin
        slice = word[slice_lo(k, IN_W, OUT_W, LSB_FIRST) +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/data_width_downsizer.sv
// Splits an IN_W-bit word into up to IN_W/OUT_W OUT_W-bit slices with valid/ready on both sides.
// Define DWC_LSB_FIRST_EN to emit slices low end first.
module data_width_downsizer
  import dwc_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  localparam int RATIO = IN_W / OUT_W,
  localparam int CNT_W = $clog2(RATIO)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic [CNT_W-1:0] len_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out,
  output logic             busy
);

  localparam bit PARAMS_OK = params_ok(IN_W, OUT_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("data_width_downsizer: IN_W must be a multiple of OUT_W with ratio >= 2");
    end
  endgenerate

  // Handshake: a beat moves on a side only at a rising clk_in edge where that
  // side's valid and ready are both high; valid_out never drops without a move.
  state_t           state_q, state_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_clamped;
  logic [OUT_W-1:0] slice;
  logic             is_last;
  logic             out_fire;
  logic             in_fire;

  dwc_slice_mux #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_slice_mux (
    .word (word_q),
    .idx  (cnt_q),
    .slice(slice)
  );

  assign is_last     = (cnt_q == len_q);
  assign valid_out   = (state_q == SEND);
  assign busy        = valid_out;
  assign last_out    = valid_out && is_last;
  assign data_out    = valid_out ? slice : '0;
  assign out_fire    = valid_out && ready_out;
  // Accept the next word in the same cycle the previous last slice leaves.
  assign ready_in    = (state_q == IDLE) || (out_fire && last_out);
  assign in_fire     = valid_in && ready_in;
  assign len_clamped = (len_in > LAST_IDX) ? LAST_IDX : len_in;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          word_d  = data_in;
          len_d   = len_clamped;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (is_last) begin
            cnt_d = '0;
            if (in_fire) begin
              word_d = data_in;
              len_d  = len_clamped;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_width_downsizer.sv
// Directed bench for data_width_downsizer (IN_W=64, OUT_W=16).
// Expected slices follow DWC_LSB_FIRST_EN when that macro is defined.
module tb_data_width_downsizer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [63:0] data_in;
  logic [1:0]  len_in;
  logic        valid_out;
  logic        ready_out;
  logic [15:0] data_out;
  logic        last_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [19:0] got;
  logic [19:0] exp;

  data_width_downsizer #(.IN_W(64), .OUT_W(16)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_in  (data_in),
    .len_in   (len_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .data_out (data_out),
    .last_out (last_out),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  // Slice k of a word in emission order.
  function automatic logic [15:0] slice_of(input logic [63:0] w, input int k);
`ifdef DWC_LSB_FIRST_EN
    return w[k*16 +: 16];
`else
    return w[63 - k*16 -: 16];
`endif
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Observed vector: {valid_out, last_out, ready_in, busy, data_out}
  task automatic sample();
    #1;
    got = {valid_out, last_out, ready_in, busy, data_out};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; len_in = '0; ready_out = 1'b1;
    #3;
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset got=%h exp=%h", got, exp);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_word();
    logic [15:0] e[4];
`ifdef DWC_LSB_FIRST_EN
    e = '{16'h0708, 16'hE5F6, 16'hC3D4, 16'hA1B2};
`else
    e = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0708};
`endif
    ready_out = 1'b1; valid_in = 1'b1; data_in = 64'hA1B2_C3D4_E5F6_0708; len_in = 2'd3;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      exp = {1'b1, (k == 3), (k == 3), 1'b1, e[k]};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL full_word beat=%0d got=%h exp=%h", k, got, exp);
      end
      step();
    end
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL full_word_idle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_backpressure();
    logic        ro[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          idx[7] = '{0, 1, 1, 1, 1, 2, 3};
    logic [63:0] w = 64'hA1B2_C3D4_E5F6_0708;
    ready_out = 1'b1; valid_in = 1'b1; data_in = w; len_in = 2'd3;
    step();
    valid_in = 1'b0;
    for (int b = 0; b < 7; b++) begin
      ready_out = ro[b];
      sample();
      exp = {1'b1, (idx[b] == 3), (idx[b] == 3), 1'b1, slice_of(w, idx[b])};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL backpressure beat=%0d got=%h exp=%h", b, got, exp);
      end
      step();
    end
    ready_out = 1'b1;
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL backpressure_idle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1 = 64'h1122_3344_5566_7788;
    logic [63:0] w2 = 64'hDEAD_BEEF_1234_5678;
    ready_out = 1'b1; valid_in = 1'b1; data_in = w1; len_in = 2'd3;
    step();
    data_in = w2;
    for (int b = 0; b < 8; b++) begin
      if (b >= 4) valid_in = 1'b0;
      sample();
      exp = {1'b1, (b % 4 == 3), (b % 4 == 3), 1'b1,
             (b < 4) ? slice_of(w1, b) : slice_of(w2, b - 4)};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL back_to_back beat=%0d got=%h exp=%h", b, got, exp);
      end
      step();
    end
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL back_to_back_idle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_short_word();
    logic [63:0] w = 64'hDEAD_BEEF_1234_5678;
    ready_out = 1'b1; valid_in = 1'b1; data_in = w; len_in = 2'd1;
    step();
    valid_in = 1'b0;
    for (int b = 0; b < 3; b++) begin
      sample();
      exp = (b < 2) ? {1'b1, (b == 1), (b == 1), 1'b1, slice_of(w, b)}
                    : {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL short_word beat=%0d got=%h exp=%h", b, got, exp);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] w = 64'h0001_0002_0003_0004;
    ready_out = 1'b1; valid_in = 1'b1; data_in = 64'hA1B2_C3D4_E5F6_0708; len_in = 2'd3;
    step();
    valid_in = 1'b0;
    step();
    rst_n = 1'b0;
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_mid_word got=%h exp=%h", got, exp);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step();
      sample();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", b, got, exp);
      end
    end
    step();
    valid_in = 1'b1; data_in = w; len_in = 2'd0;
    step();
    valid_in = 1'b0;
    sample();
    exp = {1'b1, 1'b1, 1'b1, 1'b1, slice_of(w, 0)};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL single_slice got=%h exp=%h", got, exp);
    end
    step();
    sample();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL single_slice_idle got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    step();
    test_backpressure();
    step();
    test_back_to_back();
    step();
    test_short_word();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
